// File: rtl/sig_dump_pkg.sv
// Shared types for the compliance-signature unloader.
// FSM state encoding and word-size constant.
package sig_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RUN,
        DRAIN,
        ERR,
        DONE
    } state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/sig_dump_fifo.sv
// Synchronous FIFO buffering {last,data} signature words.
// Simultaneous push and pop are both honoured.
module sig_dump_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sig_dump_ctrl.sv
// Streams TCM words [begin,end) to the host link on sim-finish.
// Optional running checksum: define SIG_DUMP_CHECKSUM_EN.
module sig_dump_ctrl
    import sig_dump_pkg::*;
#(
    parameter int ADDR_W     = 17,
    parameter int MEM_RD_LAT = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              finish_i,
    input  logic [31:0]       begin_addr_i,
    input  logic [31:0]       end_addr_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic [31:0]       mem_rd_data_i,
    output logic              sig_valid_o,
    output logic [31:0]       sig_data_o,
    output logic              sig_last_o,
    input  logic              sig_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [15:0]       word_cnt_o,
    output logic [31:0]       checksum_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_t                state;
    logic                  finish_q;
    logic [ADDR_W-1:0]     addr;
    logic [ADDR_W-1:0]     end_q;
    logic [ADDR_W-1:0]     last_addr;
    logic [ADDR_W-1:0]     b_in;
    logic [ADDR_W-1:0]     e_in;
    logic [MEM_RD_LAT-1:0] pend;
    logic [MEM_RD_LAT-1:0] pend_last;
    logic [MEM_RD_LAT:0]   pend_ext;
    logic [MEM_RD_LAT:0]   last_ext;
    logic [CW-1:0]         fifo_cnt;
    logic                  fifo_empty;
    logic [32:0]           head;
    logic                  pop;
    logic                  is_last_rd;
    int                    inflight;
    int                    credit;
    logic                  unused_hi;

    assign b_in      = begin_addr_i[ADDR_W-1:0];
    assign e_in      = end_addr_i[ADDR_W-1:0];
    assign unused_hi = ^{begin_addr_i[31:ADDR_W], end_addr_i[31:ADDR_W]};
    assign last_addr = end_q - ADDR_W'(WORD_BYTES);

    always_comb begin
        inflight = 0;
        for (int i = 0; i < MEM_RD_LAT; i++) begin
            inflight = inflight + int'(pend[i]);
        end
    end

    // A slot popped this cycle is free before any new read can land.
    assign pop    = sig_valid_o && sig_ready_i;
    assign credit = FIFO_DEPTH - int'(fifo_cnt) - inflight + int'(pop);

    assign mem_rd_en_o   = (state == RUN) && (credit > 0);
    assign mem_rd_addr_o = addr;
    assign is_last_rd    = mem_rd_en_o && (addr == last_addr);
    assign pend_ext      = {pend, mem_rd_en_o};
    assign last_ext      = {pend_last, is_last_rd};

    assign busy_o = (state == CHECK) || (state == RUN) || (state == DRAIN);

    sig_dump_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (33)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pend[MEM_RD_LAT-1]),
        .push_data ({pend_last[MEM_RD_LAT-1], mem_rd_data_i}),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    assign sig_valid_o = !fifo_empty;
    assign sig_last_o  = head[32];
    assign sig_data_o  = head[31:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            finish_q   <= 1'b0;
            addr       <= '0;
            end_q      <= '0;
            pend       <= '0;
            pend_last  <= '0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            word_cnt_o <= '0;
        end else begin
            finish_q  <= finish_i;
            pend      <= pend_ext[MEM_RD_LAT-1:0];
            pend_last <= last_ext[MEM_RD_LAT-1:0];
            if (pop) word_cnt_o <= word_cnt_o + 16'd1;
            unique case (state)
                IDLE: begin
                    if (finish_i && !finish_q) state <= CHECK;
                end
                CHECK: begin
                    addr  <= b_in;
                    end_q <= e_in;
                    if (b_in[1:0] != 2'b00 || e_in[1:0] != 2'b00 || b_in > e_in) begin
                        state <= ERR;
                    end else if (b_in == e_in) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (mem_rd_en_o) begin
                        addr <= addr + ADDR_W'(WORD_BYTES);
                        if (is_last_rd) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty && pend == '0) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
                ERR: begin
                    err_o  <= 1'b1;
                    done_o <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SIG_DUMP_CHECKSUM_EN
    logic [31:0] csum;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= '0;
        end else if (pop) begin
            csum <= csum + head[31:0];
        end
    end

    assign checksum_o = csum;
`else
    assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_sig_dump_ctrl.sv
// Scoreboard bench for sig_dump_ctrl with a 3-cycle TCM model.
// Checksum expectation follows SIG_DUMP_CHECKSUM_EN.
module tb_sig_dump_ctrl;

    localparam int ADDR_W = 17;
    localparam int LAT    = 3;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              finish_i;
    logic [31:0]       begin_addr_i;
    logic [31:0]       end_addr_i;
    logic              mem_rd_en_o;
    logic [ADDR_W-1:0] mem_rd_addr_o;
    logic [31:0]       mem_rd_data_i;
    logic              sig_valid_o;
    logic [31:0]       sig_data_o;
    logic              sig_last_o;
    logic              sig_ready_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [15:0]       word_cnt_o;
    logic [31:0]       checksum_o;

    int checks = 0;
    int errors = 0;
    int first_hs;
    int last_hs;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    sig_dump_ctrl #(
        .ADDR_W     (ADDR_W),
        .MEM_RD_LAT (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .finish_i      (finish_i),
        .begin_addr_i  (begin_addr_i),
        .end_addr_i    (end_addr_i),
        .mem_rd_en_o   (mem_rd_en_o),
        .mem_rd_addr_o (mem_rd_addr_o),
        .mem_rd_data_i (mem_rd_data_i),
        .sig_valid_o   (sig_valid_o),
        .sig_data_o    (sig_data_o),
        .sig_last_o    (sig_last_o),
        .sig_ready_i   (sig_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .word_cnt_o    (word_cnt_o),
        .checksum_o    (checksum_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h5000) return 32'hFFFF_FFFF;
        if (a == 32'h5004) return 32'h0000_0002;
        return ((a - 32'h2000) >> 2) * 32'h1111_1111;
    endfunction

    logic [31:0] rd_pipe [LAT];

    always @(posedge clk) begin
        rd_pipe[0] <= mem_word({{(32-ADDR_W){1'b0}}, mem_rd_addr_o});
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign mem_rd_data_i = rd_pipe[LAT-1];

    task automatic do_reset();
        rst          = 1'b1;
        finish_i     = 1'b0;
        sig_ready_i  = 1'b0;
        begin_addr_i = '0;
        end_addr_i   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic start(input logic [31:0] b, input logic [31:0] e, input bit legal);
        begin_addr_i = b;
        end_addr_i   = e;
        finish_i     = 1'b1;
        if (legal) begin
            for (logic [31:0] a = b; a < e; a += 4) begin
                exp_q.push_back({(a == e - 4), mem_word(a)});
            end
        end
    endtask

    // mode 0: always ready, 1: ready one cycle in three
    task automatic run_dump(input int mode, input int budget, input bit need_done,
                            output int nreads, output int nhs);
        bit          prev_stall = 1'b0;
        logic [32:0] prev = '0;
        logic [32:0] e;
        int          cyc = 0;
        nreads   = 0;
        nhs      = 0;
        first_hs = -1;
        last_hs  = -1;
        while (cyc < budget && !(need_done && done_o)) begin
            @(negedge clk);
            sig_ready_i = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            #1;
            if (mem_rd_en_o) nreads++;
            if (prev_stall) begin
                checks++;
                if (!sig_valid_o || {sig_last_o, sig_data_o} !== prev) begin
                    errors++;
                    $display("FAIL hold: got v=%0b %h, required v=1 %h",
                             sig_valid_o, {sig_last_o, sig_data_o}, prev);
                end
            end
            if (sig_valid_o && sig_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_word: got %h, required none", {sig_last_o, sig_data_o});
                end else begin
                    e = exp_q.pop_front();
                    if ({sig_last_o, sig_data_o} !== e) begin
                        errors++;
                        $display("FAIL word: got %h, required %h", {sig_last_o, sig_data_o}, e);
                    end
                end
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                nhs++;
            end
            prev_stall = sig_valid_o && !sig_ready_i;
            prev       = {sig_last_o, sig_data_o};
            cyc++;
        end
        if (need_done) begin
            checks++;
            if (!done_o) begin
                errors++;
                $display("FAIL done_timeout: got done=0, required 1 within %0d cycles", budget);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({sig_valid_o, busy_o, done_o, err_o, mem_rd_en_o, word_cnt_o, checksum_o} !== '0) begin
            errors++;
            $display("FAIL reset: got v=%0b busy=%0b done=%0b err=%0b rd=%0b cnt=%0d sum=%h, required 0",
                     sig_valid_o, busy_o, done_o, err_o, mem_rd_en_o, word_cnt_o, checksum_o);
        end
    endtask

    task automatic test_basic(input int mode);
        int r, h;
        do_reset();
        start(32'h2000, 32'h2010, 1'b1);
        run_dump(mode, 200, 1'b1, r, h);
        checks++;
        if (h != 4 || word_cnt_o !== 16'd4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_count m%0d: got hs=%0d cnt=%0d left=%0d, required 4 4 0",
                     mode, h, word_cnt_o, exp_q.size());
        end
        checks++;
        if (r != 4 || err_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_state m%0d: got reads=%0d err=%0b busy=%0b, required 4 0 0",
                     mode, r, err_o, busy_o);
        end
    endtask

    task automatic test_back_to_back();
        int r, h;
        do_reset();
        start(32'h2000, 32'h2020, 1'b1);
        run_dump(0, 200, 1'b1, r, h);
        checks++;
        if (h != 8 || last_hs - first_hs != 7) begin
            errors++;
            $display("FAIL throughput: got hs=%0d span=%0d, required 8 7", h, last_hs - first_hs);
        end
    endtask

    task automatic test_empty_range();
        int r, h;
        do_reset();
        start(32'h3000, 32'h3000, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL empty_check: got busy=%0b done=%0b, required 1 0", busy_o, done_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done_o !== 1'b1 || err_o !== 1'b0 || word_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL empty_done: got done=%0b err=%0b cnt=%0d, required 1 0 0",
                     done_o, err_o, word_cnt_o);
        end
        finish_i = 1'b0;
        run_dump(0, 4, 1'b0, r, h);
        finish_i = 1'b1;
        run_dump(0, 10, 1'b0, r, h);
        checks++;
        if (r != 0 || h != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL empty_quiet: got reads=%0d hs=%0d busy=%0b, required 0 0 0", r, h, busy_o);
        end
    endtask

    task automatic test_error(input logic [31:0] b, input logic [31:0] e);
        int r, h;
        do_reset();
        start(b, e, 1'b0);
        run_dump(0, 20, 1'b1, r, h);
        checks++;
        if (err_o !== 1'b1 || done_o !== 1'b1 || r != 0 || h != 0) begin
            errors++;
            $display("FAIL error %h-%h: got err=%0b done=%0b reads=%0d hs=%0d, required 1 1 0 0",
                     b, e, err_o, done_o, r, h);
        end
    endtask

    task automatic test_reset_midrun();
        int r, h;
        do_reset();
        start(32'h2000, 32'h2040, 1'b1);
        run_dump(0, 6, 1'b0, r, h);
        checks++;
        if (busy_o !== 1'b1 || r == 0) begin
            errors++;
            $display("FAIL midrun_busy: got busy=%0b reads=%0d, required 1 >0", busy_o, r);
        end
        do_reset();
        checks++;
        if (word_cnt_o !== 16'd0 || sig_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: got cnt=%0d v=%0b busy=%0b, required 0 0 0",
                     word_cnt_o, sig_valid_o, busy_o);
        end
        start(32'h2020, 32'h2030, 1'b1);
        run_dump(0, 200, 1'b1, r, h);
        checks++;
        if (h != 4 || word_cnt_o !== 16'd4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL restart: got hs=%0d cnt=%0d left=%0d, required 4 4 0",
                     h, word_cnt_o, exp_q.size());
        end
    endtask

    task automatic test_checksum();
        int r, h;
        logic [31:0] exp_sum;
`ifdef SIG_DUMP_CHECKSUM_EN
        exp_sum = 32'h0000_0001;
`else
        exp_sum = 32'h0000_0000;
`endif
        do_reset();
        start(32'h5000, 32'h5008, 1'b1);
        run_dump(1, 200, 1'b1, r, h);
        checks++;
        if (checksum_o !== exp_sum || h != 2) begin
            errors++;
            $display("FAIL checksum: got %h hs=%0d, required %h hs=2", checksum_o, h, exp_sum);
        end
    endtask

    initial begin
        test_reset();
        test_basic(0);
        test_basic(1);
        test_back_to_back();
        test_empty_range();
        test_error(32'h2002, 32'h3000);
        test_error(32'h4000, 32'h3000);
        test_reset_midrun();
        test_checksum();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
